// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
// Signal names keep the controller's point of view: _o is driven by the controller, _i by the memory.
interface mem_access_ctrl_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: runs EX/MEM loads/stores against a variable-latency
// data memory over req/ack, stalling the pipeline until the access completes or aborts.
module mem_access_ctrl #(
   parameter int TO_CYCLES = 255,
   parameter int TO_W      = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic [31:0]        Addr_i,
   input  logic [31:0]        WrData_i,
   output logic               stall_o,
   output logic [31:0]        RdData_o,
   output logic               RdValid_o,
   output logic               err_o,
   mem_access_ctrl_if.master  mem
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   state_t            state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rdvalid_q, rdvalid_d;
   logic              err_q, err_d;

   logic access, aligned, timeout;

   assign access  = MemRead_i | MemWrite_i;
   assign aligned = (Addr_i[1:0] == 2'b00);
   assign timeout = (cnt_q == TO_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
         rdvalid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rdvalid_q <= rdvalid_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rdvalid_d = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (access && aligned) begin
               // A simultaneous read+write is issued as a write; the read is dropped.
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = MemWrite_i;
               addr_d  = {Addr_i[31:2], 2'b00};
               wdata_d = WrData_i;
               cnt_d   = '0;
            end else if (access) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         BUSY: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (mem.mem_ack_i) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) begin
                  rdata_d   = mem.mem_rdata_i;
                  rdvalid_d = 1'b1;
               end
            end else if (timeout) begin
               state_d = DONE;
               req_d   = 1'b0;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Gated by reset so the pipeline is released the instant reset asserts.
   always_comb begin
      stall_o = 1'b0;
      if (rst_i) begin
         case (state_q)
            IDLE:    stall_o = access && aligned;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
         endcase
      end
   end

   assign RdData_o        = rdata_q;
   assign RdValid_o       = rdvalid_q;
   assign err_o           = err_q;
   assign mem.mem_req_o   = req_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a hand-driven memory (TO_CYCLES=4).
module tb_mem_access_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] Addr_i;
   logic [31:0] WrData_i;
   logic        stall_o;
   logic [31:0] RdData_o;
   logic        RdValid_o;
   logic        err_o;

   int n_checks;
   int n_fails;

   mem_access_ctrl_if mem_bus ();

   mem_access_ctrl #(.TO_CYCLES(4), .TO_W(8)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .Addr_i     (Addr_i),
      .WrData_i   (WrData_i),
      .stall_o    (stall_o),
      .RdData_o   (RdData_o),
      .RdValid_o  (RdValid_o),
      .err_o      (err_o),
      .mem        (mem_bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and land 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_i = 1'b0;
      MemRead_i = 1'b0;
      MemWrite_i = 1'b0;
      Addr_i = 32'h0;
      WrData_i = 32'h0;
      mem_bus.mem_ack_i = 1'b0;
      mem_bus.mem_rdata_i = 32'h0;

      // Reset state
      #12;
      chk("rst_req",     32'(mem_bus.mem_req_o), 32'd0);
      chk("rst_we",      32'(mem_bus.mem_we_o),  32'd0);
      chk("rst_addr",    mem_bus.mem_addr_o,     32'h0);
      chk("rst_wdata",   mem_bus.mem_wdata_o,    32'h0);
      chk("rst_rdata",   RdData_o,               32'h0);
      chk("rst_rdvalid", 32'(RdValid_o),         32'd0);
      chk("rst_err",     32'(err_o),             32'd0);
      chk("rst_stall",   32'(stall_o),           32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();

      // Load, zero-wait memory
      MemRead_i = 1'b1; Addr_i = 32'h40;
      mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hCAFE_F00D;
      #1;
      chk("ld0_stall_c0", 32'(stall_o), 32'd1);
      chk("ld0_req_c0",   32'(mem_bus.mem_req_o), 32'd0);
      tick();
      chk("ld0_stall_c1", 32'(stall_o), 32'd1);
      chk("ld0_req_c1",   32'(mem_bus.mem_req_o), 32'd1);
      chk("ld0_addr_c1",  mem_bus.mem_addr_o, 32'h40);
      chk("ld0_we_c1",    32'(mem_bus.mem_we_o), 32'd0);
      tick();
      chk("ld0_stall_c2", 32'(stall_o), 32'd0);
      chk("ld0_req_c2",   32'(mem_bus.mem_req_o), 32'd0);
      chk("ld0_rdvalid",  32'(RdValid_o), 32'd1);
      chk("ld0_rdata",    RdData_o, 32'hCAFE_F00D);
      chk("ld0_err",      32'(err_o), 32'd0);
      MemRead_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
      tick();
      chk("ld0_rdvalid_clr", 32'(RdValid_o), 32'd0);
      chk("ld0_rdata_hold",  RdData_o, 32'hCAFE_F00D);

      // Store with ack in the third BUSY cycle
      MemWrite_i = 1'b1; Addr_i = 32'h100; WrData_i = 32'h1234_5678;
      #1;
      chk("st_stall_c0", 32'(stall_o), 32'd1);
      tick();
      chk("st_stall_c1", 32'(stall_o), 32'd1);
      chk("st_we_c1",    32'(mem_bus.mem_we_o), 32'd1);
      chk("st_addr_c1",  mem_bus.mem_addr_o, 32'h100);
      chk("st_wdata_c1", mem_bus.mem_wdata_o, 32'h1234_5678);
      tick();
      chk("st_stall_c2", 32'(stall_o), 32'd1);
      chk("st_req_c2",   32'(mem_bus.mem_req_o), 32'd1);
      chk("st_addr_c2",  mem_bus.mem_addr_o, 32'h100);
      chk("st_wdata_c2", mem_bus.mem_wdata_o, 32'h1234_5678);
      tick();
      mem_bus.mem_ack_i = 1'b1;
      #1;
      chk("st_stall_c3", 32'(stall_o), 32'd1);
      chk("st_we_c3",    32'(mem_bus.mem_we_o), 32'd1);
      chk("st_addr_c3",  mem_bus.mem_addr_o, 32'h100);
      tick();
      chk("st_stall_c4", 32'(stall_o), 32'd0);
      chk("st_req_c4",   32'(mem_bus.mem_req_o), 32'd0);
      chk("st_rdvalid",  32'(RdValid_o), 32'd0);
      chk("st_err",      32'(err_o), 32'd0);
      chk("st_rdata",    RdData_o, 32'hCAFE_F00D);
      MemWrite_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
      tick();

      // Misaligned load
      MemRead_i = 1'b1; Addr_i = 32'h41;
      #1;
      chk("mis_stall_c0", 32'(stall_o), 32'd0);
      tick();
      chk("mis_req",     32'(mem_bus.mem_req_o), 32'd0);
      chk("mis_err",     32'(err_o), 32'd1);
      chk("mis_rdvalid", 32'(RdValid_o), 32'd0);
      chk("mis_stall",   32'(stall_o), 32'd0);
      chk("mis_rdata",   RdData_o, 32'hCAFE_F00D);
      MemRead_i = 1'b0;
      tick();
      chk("mis_err_clr", 32'(err_o), 32'd0);

      // Timeout: no ack for 4 BUSY cycles
      MemRead_i = 1'b1; Addr_i = 32'h200;
      tick();
      chk("to_req_b1", 32'(mem_bus.mem_req_o), 32'd1);
      tick();
      tick();
      chk("to_req_b3", 32'(mem_bus.mem_req_o), 32'd1);
      tick();
      chk("to_req_b4",   32'(mem_bus.mem_req_o), 32'd1);
      chk("to_stall_b4", 32'(stall_o), 32'd1);
      tick();
      chk("to_err",     32'(err_o), 32'd1);
      chk("to_rdata",   RdData_o, 32'h0);
      chk("to_req",     32'(mem_bus.mem_req_o), 32'd0);
      chk("to_rdvalid", 32'(RdValid_o), 32'd0);
      chk("to_stall",   32'(stall_o), 32'd0);
      MemRead_i = 1'b0;
      tick();
      chk("to_err_clr", 32'(err_o), 32'd0);

      // Ack arriving in the 4th BUSY cycle wins over the timeout
      MemRead_i = 1'b1; Addr_i = 32'h204; mem_bus.mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      tick();
      tick();
      tick();
      mem_bus.mem_ack_i = 1'b1;
      #1;
      chk("toa_req_b4", 32'(mem_bus.mem_req_o), 32'd1);
      tick();
      chk("toa_err",     32'(err_o), 32'd0);
      chk("toa_rdvalid", 32'(RdValid_o), 32'd1);
      chk("toa_rdata",   RdData_o, 32'hDEAD_BEEF);
      MemRead_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
      tick();

      // Simultaneous read and write issues a write
      MemRead_i = 1'b1; MemWrite_i = 1'b1; Addr_i = 32'h300; WrData_i = 32'hA5A5_A5A5;
      tick();
      chk("rw_we",    32'(mem_bus.mem_we_o), 32'd1);
      chk("rw_wdata", mem_bus.mem_wdata_o, 32'hA5A5_A5A5);
      mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h1111_1111;
      tick();
      chk("rw_rdvalid", 32'(RdValid_o), 32'd0);
      chk("rw_rdata",   RdData_o, 32'hDEAD_BEEF);
      chk("rw_err",     32'(err_o), 32'd0);
      MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
      tick();

      // Reset asserted during the 2nd BUSY cycle
      MemRead_i = 1'b1; Addr_i = 32'h400;
      tick();
      tick();
      chk("rb_req_b2", 32'(mem_bus.mem_req_o), 32'd1);
      rst_i = 1'b0;
      #1;
      chk("rb_req",   32'(mem_bus.mem_req_o), 32'd0);
      chk("rb_stall", 32'(stall_o), 32'd0);
      chk("rb_rdata", RdData_o, 32'h0);
      MemRead_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();
      chk("rb_stall_idle", 32'(stall_o), 32'd0);

      // Fresh load after reset release
      MemRead_i = 1'b1; Addr_i = 32'h80;
      mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h0BAD_F00D;
      tick();
      chk("pr_req",  32'(mem_bus.mem_req_o), 32'd1);
      chk("pr_addr", mem_bus.mem_addr_o, 32'h80);
      tick();
      chk("pr_rdvalid", 32'(RdValid_o), 32'd1);
      chk("pr_rdata",   RdData_o, 32'h0BAD_F00D);
      chk("pr_stall",   32'(stall_o), 32'd0);
      MemRead_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
